m_4bit_adder: RTL and testbench



---
 rtl/m_4bit_adder.sv | 92 +++++++++
 tb/tb_m_4bit_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/m_4bit_adder.sv
// m_4bit_adder: registered 4-bit ripple-carry adder with carry-in/carry-out.
// Four full-adder cells feed an output register. The register loads only on
// in_valid, and out_valid follows in_valid one clock later.
// Optional macro M_4BIT_ADDER_FLAGS_EN adds registered Ovf (signed overflow)
// and Zero (S == 0) outputs.

module m_4bit_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    // One bit of sum and carry for the ripple chain
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end
endmodule

module m_4bit_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic       out_valid,
    output logic [3:0] S,
    output logic       Cout
`ifdef M_4BIT_ADDER_FLAGS_EN
    ,
    output logic       Ovf,
    output logic       Zero
`endif
);
    localparam int W      = 4;
    localparam int STAGES = 1;

    logic [W:0]      carry;
    logic [W-1:0]    sum;
    logic [STAGES:0] vld_pipe;

    assign carry[0]    = Cin;
    assign vld_pipe[0] = in_valid;

    // Ripple chain: cell i consumes carry[i] and produces carry[i+1]
    for (genvar gi = 0; gi < W; gi++) begin : g_cell
        m_4bit_adder_fa u_fa (
            .a  (A[gi]),
            .b  (B[gi]),
            .ci (carry[gi]),
            .s  (sum[gi]),
            .co (carry[gi+1])
        );
    end

    // Valid shift register; a reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe[STAGES:1] <= '0;
        else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign out_valid = vld_pipe[STAGES];

    // Result register; holds when no operands are offered, so garbage on
    // idle inputs never reaches the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
        end else if (in_valid) begin
            S    <= sum;
            Cout <= carry[W];
        end
    end

`ifdef M_4BIT_ADDER_FLAGS_EN
    // Flag registers share the result register's load and reset rules;
    // overflow is the carry into the sign bit disagreeing with the carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ovf  <= 1'b0;
            Zero <= 1'b0;
        end else if (in_valid) begin
            Ovf  <= carry[W-1] ^ carry[W];
            Zero <= (sum == '0);
        end
    end
`endif

endmodule

// File: tb/tb_m_4bit_adder.sv
// Testbench for m_4bit_adder: scoreboard of expected results pushed at
// stimulus time, popped by an independent monitor whenever out_valid is seen.
// Build with +define+M_4BIT_ADDER_FLAGS_EN to also check Ovf and Zero.

module tb_m_4bit_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A, B;
    logic       Cin;
    logic       out_valid;
    logic [3:0] S;
    logic       Cout;
`ifdef M_4BIT_ADDER_FLAGS_EN
    logic       Ovf, Zero;
`endif

    typedef struct packed {
        logic [3:0] s;
        logic       cout;
        logic       ovf;
        logic       zero;
    } res_t;

    res_t sb[$];
    res_t last;
    int   checks = 0;
    int   errors = 0;

    m_4bit_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .S         (S),
        .Cout      (Cout)
`ifdef M_4BIT_ADDER_FLAGS_EN
        ,
        .Ovf       (Ovf),
        .Zero      (Zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer arithmetic
    function automatic res_t model(input int a, input int b, input int c);
        int   u, sg;
        res_t r;
        u      = a + b + c;
        sg     = (a > 7 ? a - 16 : a) + (b > 7 ? b - 16 : b) + c;
        r.s    = 4'(u % 16);
        r.cout = (u > 15);
        r.ovf  = (sg > 7) || (sg < -8);
        r.zero = ((u % 16) == 0);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_res(input string nm, input res_t e);
        chk({nm, " S"}, int'(S), int'(e.s));
        chk({nm, " Cout"}, int'(Cout), int'(e.cout));
`ifdef M_4BIT_ADDER_FLAGS_EN
        chk({nm, " Ovf"}, int'(Ovf), int'(e.ovf));
        chk({nm, " Zero"}, int'(Zero), int'(e.zero));
`endif
    endtask

    // Present one operand set (or an idle cycle) on the next falling edge
    task automatic drive(input bit v, input int a, input int b, input int c);
        @(negedge clk);
        in_valid = v;
        A        = 4'(a);
        B        = 4'(b);
        Cin      = 1'(c);
        if (v) sb.push_back(model(a, b, c));
    endtask

    // Directed vector checked against hand-computed constants (-1 = don't care)
    task automatic dchk(input string nm, input int a, input int b, input int c,
                        input int es, input int ec, input int eo, input int ez);
        drive(1'b1, a, b, c);
        @(posedge clk);
        #1;
        chk({nm, " out_valid"}, int'(out_valid), 1);
        chk({nm, " S"}, int'(S), es);
        chk({nm, " Cout"}, int'(Cout), ec);
`ifdef M_4BIT_ADDER_FLAGS_EN
        if (eo >= 0) chk({nm, " Ovf"}, int'(Ovf), eo);
        if (ez >= 0) chk({nm, " Zero"}, int'(Zero), ez);
`endif
    endtask

    // Monitor: pop on out_valid, otherwise outputs must hold the last result
    initial begin
        last = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                last = '0;
            end else begin
                #1;
                if (rst_n) begin
                    if (out_valid) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious out_valid: got 1 expected 0 at %0t", $time);
                        end else begin
                            last = sb.pop_front();
                            cmp_res("result", last);
                        end
                    end else begin
                        chk("latency pending", sb.size(), 0);
                        if (sb.size() != 0) sb.delete();
                        cmp_res("hold", last);
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset S", int'(S), 0);
        chk("reset Cout", int'(Cout), 0);
`ifdef M_4BIT_ADDER_FLAGS_EN
        chk("reset Ovf", int'(Ovf), 0);
        chk("reset Zero", int'(Zero), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Carry and overflow boundaries
        dchk("carry 15+0+1", 15, 0, 1, 0, 1, 0, 1);
        dchk("carry 15+15+1", 15, 15, 1, 15, 1, 0, 0);
        dchk("ovf 7+1", 7, 1, 0, 8, 0, 1, 0);
        dchk("ovf 8+8", 8, 8, 0, 0, 1, 1, 1);
        dchk("no ovf 3+4", 3, 4, 0, 7, 0, 0, 0);

        // Exhaustive sweep, back to back
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    drive(1'b1, a, b, c);

        // Hold: load 5+6, then idle with changing and unknown operands
        drive(1'b1, 5, 6, 0);
        drive(1'b0, 9, 3, 1);
        @(posedge clk);
        #1;
        chk("hold out_valid", int'(out_valid), 0);
        chk("hold S", int'(S), 11);
        chk("hold Cout", int'(Cout), 0);
        @(negedge clk);
        in_valid = 1'b0;
        A        = 'x;
        B        = 'x;
        Cin      = 1'bx;
        @(posedge clk);
        #1;
        chk("hold x S", int'(S), 11);
        chk("hold x Cout", int'(Cout), 0);

        // Randomised traffic with idle gaps
        for (int i = 0; i < 400; i++)
            drive(($urandom_range(3) != 0), int'($urandom_range(15)),
                  int'($urandom_range(15)), int'($urandom_range(1)));

        // Reset mid-stream: a result on the outputs, another operand set in flight
        drive(1'b1, 9, 4, 1);
        @(negedge clk);
        in_valid = 1'b1;
        A        = 4'd6;
        B        = 4'd6;
        Cin      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset S", int'(S), 0);
        chk("async reset Cout", int'(Cout), 0);
        chk("async reset out_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(1'b0, 1, 2, 0);
        dchk("post reset 4+4+1", 4, 4, 1, 9, 0, 1, 0);
        drive(1'b0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
